// File: rtl/axi_burst_master_pkg.sv
// Shared encodings and helpers for the AXI4 burst initiator.
// Holds the burst/resp codes, the FSM state type and the log2 size helper.
package axi_burst_master_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_e;

    // AXI size field: log2 of the bus width in bytes
    function automatic logic [2:0] axi_size(input int data_width);
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < 8; i++)
            if ((8 << i) == data_width) s = i[2:0];
        return s;
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_master_if.sv
// AXI4 master bus bundle (AW/W/B/AR/R channels) with master/slave views.
interface axi_burst_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) ();

    logic                    awvalid, awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [ID_WIDTH-1:0]     awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;

    logic                    wvalid, wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid, bready;
    logic [1:0]              bresp;
    logic [ID_WIDTH-1:0]     bid;

    logic                    arvalid, arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [ID_WIDTH-1:0]     arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;

    logic                    rvalid, rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [ID_WIDTH-1:0]     rid;
    logic                    rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        input  arready,
        input  rvalid, rdata, rresp, rid, rlast,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        output arready,
        output rvalid, rdata, rresp, rid, rlast,
        input  rready
    );

endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 initiator: one command becomes one INCR burst,
// beats stream through, and one completion carries the worst response.
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,

    input  logic                    wd_valid,
    output logic                    wd_ready,
    input  logic [DATA_WIDTH-1:0]   wd_data,
    input  logic [DATA_WIDTH/8-1:0] wd_strb,

    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_last,

    output logic                    done_valid,
    input  logic                    done_ready,
    output logic [1:0]              done_resp,

    axi_burst_master_if.master      m_axi
);

    localparam logic [2:0] AXI_SIZE = axi_size(DATA_WIDTH);

    state_e                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              len_q;
    logic [ID_WIDTH-1:0]     id_q;
    logic [8:0]              cnt;
    logic [1:0]              resp_q;
    logic                    awvalid_q, arvalid_q, done_valid_q;

    logic in_w, in_b, in_r, at_len, w_fire, r_fire, r_mismatch;
    logic [1:0] r_resp_nxt;

    assign in_w   = (state == ST_W);
    assign in_b   = (state == ST_B);
    assign in_r   = (state == ST_R);
    // 9-bit counter so a slave that overruns len never wraps back onto a match
    assign at_len = (cnt == {1'b0, len_q});
    assign w_fire = m_axi.wvalid & m_axi.wready;
    assign r_fire = m_axi.rvalid & m_axi.rready;

    assign r_mismatch = (m_axi.rid != id_q) || (m_axi.rlast != at_len);
    assign r_resp_nxt = r_mismatch ? resp_max(resp_max(resp_q, m_axi.rresp), RESP_SLVERR)
                                   : resp_max(resp_q, m_axi.rresp);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state        <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            cnt          <= '0;
            resp_q       <= RESP_OKAY;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            done_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cmd_valid) begin
                    addr_q <= cmd_addr;
                    len_q  <= cmd_len;
                    id_q   <= cmd_id;
                    cnt    <= '0;
                    resp_q <= RESP_OKAY;
                    if (cmd_write) begin
                        state     <= ST_AW;
                        awvalid_q <= 1'b1;
                    end else begin
                        state     <= ST_AR;
                        arvalid_q <= 1'b1;
                    end
                end
                ST_AW: if (m_axi.awready) begin
                    awvalid_q <= 1'b0;
                    state     <= ST_W;
                end
                ST_W: if (w_fire) begin
                    cnt <= cnt + 9'd1;
                    if (at_len) state <= ST_B;
                end
                ST_B: if (m_axi.bvalid) begin
                    resp_q       <= (m_axi.bid != id_q) ? RESP_SLVERR : m_axi.bresp;
                    done_valid_q <= 1'b1;
                    state        <= ST_DONE;
                end
                ST_AR: if (m_axi.arready) begin
                    arvalid_q <= 1'b0;
                    state     <= ST_R;
                end
                // rlast is authoritative for ending the burst; a miscount only taints resp
                ST_R: if (r_fire) begin
                    resp_q <= r_resp_nxt;
                    cnt    <= cnt + 9'd1;
                    if (m_axi.rlast) begin
                        done_valid_q <= 1'b1;
                        state        <= ST_DONE;
                    end
                end
                ST_DONE: if (done_ready) begin
                    done_valid_q <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state == ST_IDLE);
    assign done_valid = done_valid_q;
    assign done_resp  = done_valid_q ? resp_q : RESP_OKAY;

    assign m_axi.awvalid  = awvalid_q;
    assign m_axi.awaddr   = awvalid_q ? addr_q : '0;
    assign m_axi.awid     = awvalid_q ? id_q : '0;
    assign m_axi.awlen    = awvalid_q ? len_q : '0;
    assign m_axi.awsize   = awvalid_q ? AXI_SIZE : '0;
    assign m_axi.awburst  = awvalid_q ? BURST_INCR : '0;
    assign m_axi.awlock   = 1'b0;
    assign m_axi.awcache  = '0;
    assign m_axi.awprot   = '0;
    assign m_axi.awqos    = '0;
    assign m_axi.awregion = '0;

    assign m_axi.wvalid = in_w & wd_valid;
    assign wd_ready     = in_w & m_axi.wready;
    assign m_axi.wdata  = in_w ? wd_data : '0;
    assign m_axi.wstrb  = in_w ? wd_strb : '0;
    assign m_axi.wlast  = in_w & at_len;

    assign m_axi.bready = in_b;

    assign m_axi.arvalid  = arvalid_q;
    assign m_axi.araddr   = arvalid_q ? addr_q : '0;
    assign m_axi.arid     = arvalid_q ? id_q : '0;
    assign m_axi.arlen    = arvalid_q ? len_q : '0;
    assign m_axi.arsize   = arvalid_q ? AXI_SIZE : '0;
    assign m_axi.arburst  = arvalid_q ? BURST_INCR : '0;
    assign m_axi.arlock   = 1'b0;
    assign m_axi.arcache  = '0;
    assign m_axi.arprot   = '0;
    assign m_axi.arqos    = '0;
    assign m_axi.arregion = '0;

    assign m_axi.rready = in_r & rd_ready;
    assign rd_valid     = in_r & m_axi.rvalid;
    assign rd_data      = in_r ? m_axi.rdata : '0;
    assign rd_last      = in_r & m_axi.rlast;

endmodule
